// File: rtl/snes_controller_device.sv
`default_nettype none
// ============================================================================
//  Module      : snes_controller_device
//  Description : Console-facing SNES gamepad emulator. It synchronizes the
//                host latch and shift clock, snapshots the button vector and
//                shifts it out active-low, one bit per data_clk rise.
//  Revision    : 1.0 - initial release
// ============================================================================
module snes_controller_device #(
  parameter int SNES_BUTTON_COUNT = 12,
  parameter int FRAME_BITS        = 16,
  parameter int SYNC_STAGES       = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         data_latch,
  input  logic                         data_clk,
  input  logic [SNES_BUTTON_COUNT-1:0] button_state,
  output logic                         serial_out,
  output logic                         frame_active,
  output logic                         frame_done
);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_LOAD  = 2'd1;
  localparam logic [1:0] c_SHIFT = 2'd2;
  localparam logic [1:0] c_DONE  = 2'd3;

  localparam logic [4:0] c_LAST_BIT = 5'(FRAME_BITS - 1);
  localparam logic [4:0] c_FULL     = 5'(FRAME_BITS);

  logic [SYNC_STAGES-1:0] r_latch_sync;
  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic                   r_clk_prev;
  logic [1:0]             r_state;
  logic [FRAME_BITS-1:0]  r_sr;
  logic [4:0]             r_bit_cnt;
  logic                   r_frame_active;
  logic                   r_frame_done;

  logic                   w_latch_lvl;
  logic                   w_clk_rise;
  logic [FRAME_BITS-1:0]  w_load_val;

  // A level-high latch outside LOAD is always a fresh rise, since LOAD is
  // only left once the synchronized latch has dropped.
  assign w_latch_lvl = r_latch_sync[SYNC_STAGES-1];
  assign w_clk_rise  = r_clk_sync[SYNC_STAGES-1] & ~r_clk_prev;
  assign w_load_val  = {{(FRAME_BITS-SNES_BUTTON_COUNT){1'b1}}, ~button_state};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_latch_sync <= '0;
      r_clk_sync   <= '0;
      r_clk_prev   <= 1'b0;
    end else begin
      r_latch_sync <= {r_latch_sync[SYNC_STAGES-2:0], data_latch};
      r_clk_sync   <= {r_clk_sync[SYNC_STAGES-2:0], data_clk};
      r_clk_prev   <= r_clk_sync[SYNC_STAGES-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= c_IDLE;
      r_sr           <= '1;
      r_bit_cnt      <= '0;
      r_frame_active <= 1'b0;
      r_frame_done   <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        c_IDLE: begin
          if (w_latch_lvl) begin
            r_state   <= c_LOAD;
            r_sr      <= w_load_val;
            r_bit_cnt <= '0;
          end
        end
        c_LOAD: begin
          r_bit_cnt <= '0;
          if (!w_latch_lvl) begin
            r_state        <= c_SHIFT;
            r_frame_active <= 1'b1;
          end else begin
            r_sr <= w_load_val;
          end
        end
        c_SHIFT: begin
          // Latch has priority over a coincident shift strobe.
          if (w_latch_lvl) begin
            r_state        <= c_LOAD;
            r_sr           <= w_load_val;
            r_bit_cnt      <= '0;
            r_frame_active <= 1'b0;
          end else if (w_clk_rise) begin
            r_sr <= {1'b1, r_sr[FRAME_BITS-1:1]};
            if (r_bit_cnt != c_FULL) begin
              r_bit_cnt <= r_bit_cnt + 5'd1;
            end
            if (r_bit_cnt == c_LAST_BIT) begin
              r_state        <= c_DONE;
              r_frame_done   <= 1'b1;
              r_frame_active <= 1'b0;
            end
          end
        end
        c_DONE: begin
          if (w_latch_lvl) begin
            r_state   <= c_LOAD;
            r_sr      <= w_load_val;
            r_bit_cnt <= '0;
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  always_comb begin
    serial_out = 1'b1;
    case (r_state)
      c_LOAD, c_SHIFT: serial_out = r_sr[0];
      c_DONE:          serial_out = 1'b0;
      default:         serial_out = 1'b1;
    endcase
  end

  assign frame_active = r_frame_active;
  assign frame_done   = r_frame_done;

endmodule
`default_nettype wire
